morse_key_timer: RTL and testbench



---
 rtl/morse_pkg.sv | 42 ++++
 rtl/key_debounce.sv | 54 +++++
 rtl/morse_key_timer.sv | 158 +++++++++++++++
 tb/tb_morse_key_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// ============================================================================
//  Package  : morse_pkg
//  Purpose  : FSM/symbol types and default timing shared by the Morse path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_WGAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_DOT  = 2'd1,
        SYM_DASH = 2'd2
    } symbol_e;

    localparam int MORSE_CNT_W    = 6;
    localparam int MORSE_DEBOUNCE = 2;
    localparam int MORSE_DOT_MAX  = 5;
    localparam int MORSE_CHAR_GAP = 10;
    localparam int MORSE_WORD_GAP = 30;

    function automatic symbol_e classify_press(input int unsigned len,
                                               input int unsigned dot_max);
        if (len == 0) begin
            return SYM_NONE;
        end else if (len <= dot_max) begin
            return SYM_DOT;
        end else begin
            return SYM_DASH;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Two-flop synchroniser followed by a stable-sample debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_db_o
);

    localparam int                 c_CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic               sync1_q;
    logic               sync2_q;
    logic               db_q;
    logic [c_CNT_W-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the debounced level;
    // any agreeing sample restarts the count, so short glitches are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            if (sync2_q != db_q) begin
                if (cnt_q == c_LAST) begin
                    db_q  <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + c_ONE;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign key_db_o = db_q;

endmodule

`default_nettype wire

// File: rtl/morse_key_timer.sv
// ============================================================================
//  Module   : morse_key_timer
//  Purpose  : Debounces the Morse key and times presses/gaps into dot, dash,
//             char_end and (with MORSE_WORD_GAP_EN defined) word_end strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_key_timer
    import morse_pkg::*;
#(
    parameter int CNT_W    = MORSE_CNT_W,
    parameter int DEBOUNCE = MORSE_DEBOUNCE,
    parameter int DOT_MAX  = MORSE_DOT_MAX,
    parameter int CHAR_GAP = MORSE_CHAR_GAP,
    parameter int WORD_GAP = MORSE_WORD_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_i,
    output logic             dot_o,
    output logic             dash_o,
    output logic             char_end_o,
    output logic             word_end_o,
    output logic [CNT_W-1:0] press_len_o,
    output logic             key_db_o
);

    localparam int                 c_GAP_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0]   c_LEN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_LEN_MAX  = '1;
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0] c_CHAR_END = c_GAP_W'(CHAR_GAP);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [c_GAP_W-1:0] c_WORD_END = c_GAP_W'(CHAR_GAP + WORD_GAP);
    localparam state_e             c_GAP_EXIT = ST_WGAP;
`else
    localparam state_e             c_GAP_EXIT = ST_IDLE;
`endif

    if (CHAR_GAP + WORD_GAP >= (1 << c_GAP_W)) begin : g_gap_cfg_err
        $error("morse_key_timer: CHAR_GAP+WORD_GAP does not fit in the gap counter");
    end

    logic               key_db;
    state_e             state_q;
    logic [CNT_W-1:0]   press_len_q;
    logic [CNT_W-1:0]   press_len_d;
    logic [c_GAP_W-1:0] gap_cnt_q;
    logic [c_GAP_W-1:0] gap_cnt_d;
    logic               dot_q;
    logic               dash_q;
    logic               char_end_q;
    symbol_e            press_sym;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_i    (key_i),
        .key_db_o (key_db)
    );

    assign press_len_d = (press_len_q == c_LEN_MAX) ? press_len_q : press_len_q + c_LEN_ONE;
    assign gap_cnt_d   = gap_cnt_q + c_GAP_ONE;
    assign press_sym   = classify_press(32'(press_len_q), DOT_MAX);

`ifdef MORSE_WORD_GAP_EN
    logic word_end_q;
`endif

    // gap_cnt_d is compared so that expiry lands exactly CHAR_GAP cycles after
    // the dot/dash strobe; a same-cycle rise still reports char_end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            press_len_q <= '0;
            gap_cnt_q   <= '0;
            dot_q       <= 1'b0;
            dash_q      <= 1'b0;
            char_end_q  <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            word_end_q  <= 1'b0;
`endif
        end else begin
            dot_q      <= 1'b0;
            dash_q     <= 1'b0;
            char_end_q <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            word_end_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (key_db) begin
                        state_q     <= ST_PRESS;
                        press_len_q <= c_LEN_ONE;
                    end
                end
                ST_PRESS: begin
                    if (key_db) begin
                        press_len_q <= press_len_d;
                    end else begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                        dot_q     <= (press_sym == SYM_DOT);
                        dash_q    <= (press_sym == SYM_DASH);
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_d;
                    if (gap_cnt_d == c_CHAR_END) begin
                        char_end_q <= 1'b1;
                        if (key_db) begin
                            state_q     <= ST_PRESS;
                            press_len_q <= c_LEN_ONE;
                        end else begin
                            state_q     <= c_GAP_EXIT;
                            press_len_q <= '0;
                        end
                    end else if (key_db) begin
                        state_q     <= ST_PRESS;
                        press_len_q <= c_LEN_ONE;
                    end
                end
`ifdef MORSE_WORD_GAP_EN
                ST_WGAP: begin
                    gap_cnt_q <= gap_cnt_d;
                    if (key_db) begin
                        state_q     <= ST_PRESS;
                        press_len_q <= c_LEN_ONE;
                    end else if (gap_cnt_d == c_WORD_END) begin
                        word_end_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dot_o       = dot_q;
    assign dash_o      = dash_q;
    assign char_end_o  = char_end_q;
    assign press_len_o = press_len_q;
    assign key_db_o    = key_db;
`ifdef MORSE_WORD_GAP_EN
    assign word_end_o  = word_end_q;
`else
    assign word_end_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_morse_key_timer.sv
// ============================================================================
//  Module   : tb_morse_key_timer
//  Purpose  : Directed self-checking bench for morse_key_timer (default timing).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_key_timer;

    localparam int CNT_W = 6;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_i = 1'b0;
    logic             dot_o;
    logic             dash_o;
    logic             char_end_o;
    logic             word_end_o;
    logic [CNT_W-1:0] press_len_o;
    logic             key_db_o;

    always #5 clk = ~clk;

    morse_key_timer #(
        .CNT_W    (6),
        .DEBOUNCE (2),
        .DOT_MAX  (5),
        .CHAR_GAP (10),
        .WORD_GAP (30)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_i       (key_i),
        .dot_o       (dot_o),
        .dash_o      (dash_o),
        .char_end_o  (char_end_o),
        .word_end_o  (word_end_o),
        .press_len_o (press_len_o),
        .key_db_o    (key_db_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    int n_dot, n_dash, n_char, n_word, n_db_high, n_overlap = 0;
    int dot_cyc, dash_cyc, char_cyc, word_cyc, dot_first, char_first;
    int dot_len, dash_len, char_len, max_len;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dot_o) begin
            if (n_dot == 0) dot_first = cyc;
            n_dot++; dot_cyc = cyc; dot_len = int'(press_len_o);
        end
        if (dash_o) begin
            n_dash++; dash_cyc = cyc; dash_len = int'(press_len_o);
        end
        if (char_end_o) begin
            if (n_char == 0) char_first = cyc;
            n_char++; char_cyc = cyc; char_len = int'(press_len_o);
        end
        if (word_end_o) begin
            n_word++; word_cyc = cyc;
        end
        if (key_db_o) n_db_high++;
        if (int'(press_len_o) > max_len) max_len = int'(press_len_o);
        if (int'(dot_o) + int'(dash_o) + int'(char_end_o) + int'(word_end_o) > 1) n_overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        n_dot = 0; n_dash = 0; n_char = 0; n_word = 0; n_db_high = 0;
        dot_cyc = 0; dash_cyc = 0; char_cyc = 0; word_cyc = 0;
        dot_first = 0; char_first = 0;
        dot_len = 0; dash_len = 0; char_len = 0; max_len = 0;
    endtask

    // Called on a falling edge: key_i is high for exactly n rising edges.
    task automatic press(input int n);
        key_i = 1'b1;
        repeat (n) @(negedge clk);
        key_i = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_dot"},      dot_o,       0);
        check_eq({tag, "_dash"},     dash_o,      0);
        check_eq({tag, "_char_end"}, char_end_o,  0);
        check_eq({tag, "_word_end"}, word_end_o,  0);
        check_eq({tag, "_len"},      press_len_o, 0);
        check_eq({tag, "_key_db"},   key_db_o,    0);
    endtask

    initial begin
        clear_log();
        rst_n = 1'b0;
        key_i = 1'b0;
        idle(3);
        check_quiet("reset");
        rst_n = 1'b1;
        idle(5);

        // press 3: a dot 5 cycles after release, char_end 10 after the dot
        clear_log();
        press(3);
        idle(50);
        check_eq("a_dots",      n_dot, 1);
        check_eq("a_dashes",    n_dash, 0);
        check_eq("a_dot_len",   dot_len, 3);
        check_eq("a_dot_lat",   dot_cyc - rel_cyc, 5);
        check_eq("a_db_cycles", n_db_high, 3);
        check_eq("a_chars",     n_char, 1);
        check_eq("a_char_lat",  char_cyc - dot_cyc, 10);
        check_eq("a_char_len",  char_len, 0);

        // press 5 (boundary dot), gap 4, press 6 (shortest dash)
        clear_log();
        press(5);
        idle(4);
        press(6);
        idle(50);
        check_eq("b_dots",      n_dot, 1);
        check_eq("b_dot_len",   dot_len, 5);
        check_eq("b_dashes",    n_dash, 1);
        check_eq("b_dash_len",  dash_len, 6);
        check_eq("b_sym_gap",   dash_cyc - dot_cyc, 10);
        check_eq("b_chars",     n_char, 1);
        check_eq("b_char_lat",  char_cyc - dash_cyc, 10);

        // one-cycle glitch never reaches key_db
        clear_log();
        key_i = 1'b1;
        @(negedge clk);
        key_i = 1'b0;
        idle(50);
        check_eq("c_db_cycles", n_db_high, 0);
        check_eq("c_strobes",   n_dot + n_dash + n_char, 0);
        check_eq("c_max_len",   max_len, 0);

        // 9-cycle release: no letter gap between the two dots
        clear_log();
        press(3);
        idle(9);
        press(2);
        idle(50);
        check_eq("d_dots",      n_dot, 2);
        check_eq("d_chars",     n_char, 1);
        check_eq("d_dot2_len",  dot_len, 2);
        check_eq("d_char_lat",  char_cyc - dot_cyc, 10);

        // 10-cycle release: char_end coincides with the next rise
        clear_log();
        press(3);
        idle(10);
        press(2);
        idle(50);
        check_eq("e_dots",      n_dot, 2);
        check_eq("e_chars",     n_char, 2);
        check_eq("e_char1_lat", char_first - dot_first, 10);
        check_eq("e_dot2_len",  dot_len, 2);

        // press 100: saturating length, single dash
        clear_log();
        press(100);
        idle(60);
        check_eq("f_max_len",   max_len, 63);
        check_eq("f_dashes",    n_dash, 1);
        check_eq("f_dash_len",  dash_len, 63);
        check_eq("f_dots",      n_dot, 0);
        check_eq("f_chars",     n_char, 1);
`ifdef MORSE_WORD_GAP_EN
        check_eq("f_words",     n_word, 1);
        check_eq("f_word_lat",  word_cyc - char_cyc, 30);
`else
        check_eq("f_words",     n_word, 0);
`endif

        // reset in the middle of a press discards the pending symbol
        key_i = 1'b1;
        idle(20);
        rst_n = 1'b0;
        key_i = 1'b0;
        @(negedge clk);
        clear_log();
        @(negedge clk);
        check_quiet("g_rst");
        rst_n = 1'b1;
        idle(40);
        check_eq("g_strobes",   n_dot + n_dash + n_char + n_word, 0);
        check_eq("g_max_len",   max_len, 0);
        check_eq("g_db_cycles", n_db_high, 0);

        check_eq("overlap",     n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
